// File: rtl/pci_bus_arbiter.sv
// rtl/pci_bus_arbiter.sv - round-robin central PCI bus arbiter with grant timeout and tenure bound
// Ports:
//   clk        bus clock, all state changes on posedge
//   rst_n      asynchronous active-low reset
//   REQ        active-low per-device request (bit i = device i)
//   FRAME      active-low PCI FRAME, observed only
//   IRDY       active-low PCI IRDY, observed only
//   GNT        active-low per-device grant, registered, at most one bit low
//   owner      index of the device granted or owning the bus
//   owner_vld  high while a device is granted (GRANT) or owns the bus (BUSY)
module pci_bus_arbiter #(
    parameter int NUM_DEV       = 3,
    parameter int GRANT_TIMEOUT = 16,
    parameter int MAX_HOLD      = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_DEV-1:0] REQ,
    input  logic               FRAME,
    input  logic               IRDY,
    output logic [NUM_DEV-1:0] GNT,
    output logic [1:0]         owner,
    output logic               owner_vld
);

    localparam int IW = $clog2(GRANT_TIMEOUT);
    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_BUSY, S_TURN} state_t;

    state_t             state, state_nxt;
    logic [NUM_DEV-1:0] req_q;
    logic [NUM_DEV-1:0] gnt_q, gnt_nxt;
    logic [1:0]         owner_q, owner_nxt;
    logic [1:0]         rr_ptr, rr_nxt;
    logic [IW-1:0]      idle_cnt, idle_nxt;
    logic [HW-1:0]      hold_cnt, hold_nxt;
    logic [1:0]         winner;
    logic               found;
    logic [2:0]         cand;
    logic [NUM_DEV-1:0] own_mask;
    logic               owner_req;
    logic               others_req;

    // Round-robin search over the registered request vector, starting at rr_ptr.
    // rr_ptr < NUM_DEV <= 4, so one conditional subtraction implements the wrap.
    always_comb begin
        found  = 1'b0;
        winner = 2'd0;
        cand   = 3'd0;
        for (int i = 0; i < NUM_DEV; i++) begin
            cand = {1'b0, rr_ptr} + 3'(i);
            if (cand >= 3'(NUM_DEV)) begin
                cand = cand - 3'(NUM_DEV);
            end
            if (!found && !req_q[cand[1:0]]) begin
                found  = 1'b1;
                winner = cand[1:0];
            end
        end
    end

    assign own_mask   = NUM_DEV'(1) << owner_q;
    assign owner_req  = ~req_q[owner_q];
    assign others_req = |(~req_q & ~own_mask);

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt_q;
        owner_nxt = owner_q;
        rr_nxt    = rr_ptr;
        idle_nxt  = idle_cnt;
        hold_nxt  = hold_cnt;
        case (state)
            S_IDLE: begin
                gnt_nxt = '1;
                if (found) begin
                    state_nxt = S_GRANT;
                    gnt_nxt   = ~(NUM_DEV'(1) << winner);
                    owner_nxt = winner;
                    rr_nxt    = (winner == 2'(NUM_DEV - 1)) ? 2'd0 : winner + 2'd1;
                    idle_nxt  = '0;
                end
            end
            S_GRANT: begin
                if (!FRAME) begin
                    state_nxt = S_BUSY;
                    hold_nxt  = '0;
                end else if (!owner_req || (idle_cnt == IW'(GRANT_TIMEOUT - 1))) begin
                    state_nxt = S_TURN;
                    gnt_nxt   = '1;
                end else begin
                    idle_nxt = idle_cnt + IW'(1);
                end
            end
            S_BUSY: begin
                if (hold_cnt < HW'(MAX_HOLD)) begin
                    hold_nxt = hold_cnt + HW'(1);
                end
                if (FRAME && IRDY) begin
                    state_nxt = S_TURN;
                    gnt_nxt   = '1;
                end else if (!owner_req || ((hold_cnt >= HW'(MAX_HOLD)) && others_req)) begin
                    // Grant removed, but the master keeps the bus until its transaction ends.
                    gnt_nxt = '1;
                end
            end
            S_TURN: begin
                state_nxt = S_IDLE;
                gnt_nxt   = '1;
            end
            default: begin
                state_nxt = S_IDLE;
                gnt_nxt   = '1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            req_q    <= '1;
            gnt_q    <= '1;
            owner_q  <= 2'd0;
            rr_ptr   <= 2'd0;
            idle_cnt <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            req_q    <= REQ;
            gnt_q    <= gnt_nxt;
            owner_q  <= owner_nxt;
            rr_ptr   <= rr_nxt;
            idle_cnt <= idle_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    assign GNT       = gnt_q;
    assign owner     = owner_q;
    assign owner_vld = (state == S_GRANT) || (state == S_BUSY);

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// tb/tb_pci_bus_arbiter.sv - directed self-checking bench for pci_bus_arbiter
module tb_pci_bus_arbiter;

    logic       clk;
    logic       rst_n;
    logic [2:0] REQ;
    logic       FRAME;
    logic       IRDY;
    logic [2:0] GNT;
    logic [1:0] owner;
    logic       owner_vld;

    int checks = 0;
    int errors = 0;

    pci_bus_arbiter #(
        .NUM_DEV(3),
        .GRANT_TIMEOUT(16),
        .MAX_HOLD(32)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .REQ(REQ),
        .FRAME(FRAME),
        .IRDY(IRDY),
        .GNT(GNT),
        .owner(owner),
        .owner_vld(owner_vld)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tenure(input int n);
        FRAME = 1'b0;
        IRDY  = 1'b0;
        repeat (n) step();
        FRAME = 1'b1;
        IRDY  = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        REQ   = 3'b000;
        FRAME = 1'b1;
        IRDY  = 1'b1;

        // Reset with everyone requesting
        step();
        step();
        check("rst_gnt", GNT, 3'b111);
        check("rst_vld", owner_vld, 1'b0);
        check("rst_owner", owner, 2'd0);
        rst_n = 1'b1;
        step();
        check("rel_edge1_gnt", GNT, 3'b111);
        step();
        check("rel_edge2_gnt", GNT, 3'b110);
        check("rel_edge2_owner", owner, 2'd0);
        check("rel_edge2_vld", owner_vld, 1'b1);

        // Round robin 0 -> 1 -> 2 -> 0 with 2-cycle tenures
        tenure(2);
        check("rr0_busy_vld", owner_vld, 1'b1);
        step();
        check("rr0_turn_gnt", GNT, 3'b111);
        check("rr0_turn_vld", owner_vld, 1'b0);
        step();
        check("rr0_idle_gnt", GNT, 3'b111);
        step();
        check("rr1_gnt", GNT, 3'b101);
        check("rr1_owner", owner, 2'd1);
        tenure(2);
        step();
        check("rr1_turn_gnt", GNT, 3'b111);
        step();
        check("rr1_idle_gnt", GNT, 3'b111);
        step();
        check("rr2_gnt", GNT, 3'b011);
        check("rr2_owner", owner, 2'd2);
        tenure(2);
        step();
        check("rr2_turn_gnt", GNT, 3'b111);
        step();
        step();
        check("rr0b_gnt", GNT, 3'b110);
        check("rr0b_owner", owner, 2'd0);

        // Device 0 withdraws while granted; devices 1 and 2 request
        REQ = 3'b001;
        step();
        check("wd0_still_gnt", GNT, 3'b110);
        step();
        check("wd0_turn_gnt", GNT, 3'b111);
        check("wd0_turn_vld", owner_vld, 1'b0);
        step();
        step();
        check("to_grant1_gnt", GNT, 3'b101);
        check("to_grant1_owner", owner, 2'd1);

        // Grant timeout: GNT[1] stays low 16 cycles with FRAME idle
        repeat (15) step();
        check("to_before_gnt", GNT, 3'b101);
        check("to_before_vld", owner_vld, 1'b1);
        step();
        check("to_revoke_gnt", GNT, 3'b111);
        check("to_revoke_vld", owner_vld, 1'b0);
        step();
        step();
        check("to_next_gnt", GNT, 3'b011);
        check("to_next_owner", owner, 2'd2);

        // Withdraw before FRAME, then no spurious grants; FRAME in IDLE ignored
        REQ = 3'b111;
        step();
        check("wd2_still_gnt", GNT, 3'b011);
        step();
        check("wd2_turn_gnt", GNT, 3'b111);
        check("wd2_turn_vld", owner_vld, 1'b0);
        FRAME = 1'b0;
        IRDY  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check("idle_frame_gnt", GNT, 3'b111);
            check("idle_frame_vld", owner_vld, 1'b0);
        end
        check("idle_owner_hold", owner, 2'd2);
        FRAME = 1'b1;
        IRDY  = 1'b1;

        // Max hold: device 0 holds FRAME 40 cycles while device 2 requests
        REQ = 3'b010;
        step();
        step();
        check("mh_grant_gnt", GNT, 3'b110);
        check("mh_grant_owner", owner, 2'd0);
        FRAME = 1'b0;
        IRDY  = 1'b0;
        repeat (33) step();
        check("mh_b32_gnt", GNT, 3'b110);
        step();
        check("mh_revoke_gnt", GNT, 3'b111);
        check("mh_revoke_vld", owner_vld, 1'b1);
        repeat (6) step();
        check("mh_hold_gnt", GNT, 3'b111);
        check("mh_hold_vld", owner_vld, 1'b1);
        FRAME = 1'b1;
        IRDY  = 1'b1;
        step();
        check("mh_turn_gnt", GNT, 3'b111);
        check("mh_turn_vld", owner_vld, 1'b0);
        step();
        check("mh_idle_gnt", GNT, 3'b111);
        step();
        check("mh_next_gnt", GNT, 3'b011);
        check("mh_next_owner", owner, 2'd2);

        // Async reset in the middle of a device-0 tenure (rr_ptr is 1 beforehand)
        tenure(2);
        step();
        check("ar_turn_gnt", GNT, 3'b111);
        step();
        step();
        check("ar_grant0_gnt", GNT, 3'b110);
        FRAME = 1'b0;
        IRDY  = 1'b0;
        step();
        check("ar_busy_vld", owner_vld, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("ar_async_gnt", GNT, 3'b111);
        check("ar_async_vld", owner_vld, 1'b0);
        #1 rst_n = 1'b1;
        FRAME = 1'b1;
        IRDY  = 1'b1;
        step();
        check("ar_edge1_gnt", GNT, 3'b111);
        step();
        check("ar_rrptr_gnt", GNT, 3'b110);
        check("ar_rrptr_owner", owner, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
